dcache_direct_wb: RTL and testbench

- Direct-mapped, write-back, write-allocate data cache. Responder to the CPU's stage-4 data memory port: read/write strobe, ALU address, store data, load data, busywait.
- Initiator toward the 128-bit-block data memory using the same busywait handshake the instruction cache uses toward instruction memory.
- A miss stalls the CPU pipeline through busywait until the line is refilled.

---
 rtl/dcache_direct_wb.sv | 144 ++++++++++++++
 tb/tb_dcache_direct_wb.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_direct_wb.sv
// Direct-mapped write-back write-allocate data cache with a 128-bit block memory port.
// Optional hit/miss counters are enabled by defining DCACHE_STATS_EN.
module dcache_direct_wb #(
  parameter int NUM_SETS = 8
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         read,
  input  logic         write,
  input  logic [31:0]  address,
  input  logic [31:0]  writedata,
  output logic [31:0]  readdata,
  output logic         busywait,
  output logic         mem_read,
  output logic         mem_write,
  output logic [27:0]  mem_address,
  output logic [127:0] mem_writedata,
  input  logic [127:0] mem_readdata,
  input  logic         mem_busywait
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]  hit_count,
  output logic [31:0]  miss_count
`endif
);

  localparam int IW = $clog2(NUM_SETS);
  localparam int TW = 28 - IW;

  typedef enum logic [1:0] {
    IDLE, WBACK, FETCH, UPDATE
  } state_t;

  state_t state;

  logic [127:0]        data_q [NUM_SETS];
  logic [TW-1:0]       tag_q  [NUM_SETS];
  logic [NUM_SETS-1:0] valid_q;
  logic [NUM_SETS-1:0] dirty_q;
  logic [31:0]         rd_q;

  logic [IW-1:0] idx;
  logic [TW-1:0] tag;
  logic [1:0]    off;
  logic [127:0]  line;
  logic [31:0]   word;
  logic          hit;
  logic          req;
  logic          rd_hit;
  logic          wr_hit;
  logic          unused_ok;

  assign idx  = address[3+IW:4];
  assign tag  = address[31:4+IW];
  assign off  = address[3:2];
  assign line = data_q[idx];
  assign word = line[{off, 5'b0} +: 32];
  assign hit  = valid_q[idx] && (tag_q[idx] == tag);
  assign req  = read | write;

  assign rd_hit = (state == IDLE) && read && !write && hit;
  assign wr_hit = (state == IDLE) && write && hit;
  assign unused_ok = ^address[1:0];

  // Hit data bypasses the register so loads that hit never stall
  assign readdata = rd_hit ? word : rd_q;
  assign busywait = !RESET &&
                    ((state != IDLE) || (req && !hit));

  assign mem_read  = (state == FETCH);
  assign mem_write = (state == WBACK);

  always_comb begin
    mem_address   = '0;
    mem_writedata = '0;
    if (state == FETCH) begin
      mem_address = address[31:4];
    end else if (state == WBACK) begin
      mem_address   = {tag_q[idx], idx};
      mem_writedata = line;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state   <= IDLE;
      valid_q <= '0;
      dirty_q <= '0;
      rd_q    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req && hit) begin
            if (write) dirty_q[idx] <= 1'b1;
            else       rd_q <= word;
          end else if (req) begin
            state <= (valid_q[idx] && dirty_q[idx]) ? WBACK : FETCH;
          end
        end
        WBACK: begin
          if (!mem_busywait) state <= FETCH;
        end
        FETCH: begin
          if (!mem_busywait) state <= UPDATE;
        end
        UPDATE: begin
          valid_q[idx] <= 1'b1;
          dirty_q[idx] <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

  // Refill lands in the array at fetch completion; the line only turns valid in UPDATE
  always_ff @(posedge CLK) begin
    if (wr_hit) begin
      data_q[idx][{off, 5'b0} +: 32] <= writedata;
    end else if (state == FETCH && !mem_busywait) begin
      data_q[idx] <= mem_readdata;
      tag_q[idx]  <= tag;
    end
  end

`ifdef DCACHE_STATS_EN
  logic refill_q;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      hit_count  <= '0;
      miss_count <= '0;
      refill_q   <= 1'b0;
    end else begin
      if (state == UPDATE)    refill_q <= 1'b1;
      else if (state == IDLE) refill_q <= 1'b0;
      if (state == IDLE && req) begin
        if (!hit)           miss_count <= miss_count + 32'd1;
        else if (!refill_q) hit_count  <= hit_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dcache_direct_wb.sv
// Randomized self-checking bench for dcache_direct_wb against a block-level cache model.
// Counter ports are checked when DCACHE_STATS_EN is defined.
module tb_dcache_direct_wb;

  localparam int NS = 8;

  logic         CLK;
  logic         RESET;
  logic         read;
  logic         write;
  logic [31:0]  address;
  logic [31:0]  writedata;
  logic [31:0]  readdata;
  logic         busywait;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_address;
  logic [127:0] mem_writedata;
  logic [127:0] mem_readdata;
  logic         mem_busywait;
`ifdef DCACHE_STATS_EN
  logic [31:0]  hit_count;
  logic [31:0]  miss_count;
`endif

  dcache_direct_wb #(.NUM_SETS(NS)) dut (
    .CLK(CLK),
    .RESET(RESET),
    .read(read),
    .write(write),
    .address(address),
    .writedata(writedata),
    .readdata(readdata),
    .busywait(busywait),
    .mem_read(mem_read),
    .mem_write(mem_write),
    .mem_address(mem_address),
    .mem_writedata(mem_writedata),
    .mem_readdata(mem_readdata),
    .mem_busywait(mem_busywait)
`ifdef DCACHE_STATS_EN
    ,
    .hit_count(hit_count),
    .miss_count(miss_count)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  // Backing memory: 1024 words, fixed latency per transfer
  logic [31:0] phys    [1024];
  logic [31:0] ref_mem [1024];
  int rd_lat = 0;
  int wb_lat = 0;
  int cnt = 0;
  int cur_lat;

  assign cur_lat = mem_write ? wb_lat : rd_lat;
  assign mem_busywait = (mem_read | mem_write) && (cnt < cur_lat);
  assign mem_readdata = {phys[{mem_address[7:0], 2'd3}],
                         phys[{mem_address[7:0], 2'd2}],
                         phys[{mem_address[7:0], 2'd1}],
                         phys[{mem_address[7:0], 2'd0}]};

  always @(posedge CLK) begin
    if (mem_read | mem_write) begin
      if (cnt >= cur_lat) begin
        cnt <= 0;
        if (mem_write) begin
          for (int w = 0; w < 4; w++)
            phys[{mem_address[7:0], w[1:0]}] <= mem_writedata[w*32 +: 32];
        end
      end else begin
        cnt <= cnt + 1;
      end
    end else begin
      cnt <= 0;
    end
  end

  // Model: which block each set holds and whether it differs from memory
  bit          m_valid [NS];
  bit          m_dirty [NS];
  int          m_blk   [NS];
  int          model_hits = 0;
  int          model_misses = 0;
  logic [31:0] last_rd = 0;
  logic [27:0] exp_fetch = 0;
  logic [27:0] exp_wb_addr = 0;
  logic [127:0] exp_wb_data = 0;
  bit          exp_wb = 0;
  bit          run = 0;
  logic [27:0] obs_fetch = 0;
  logic [27:0] obs_wb_addr = 0;
  logic [127:0] obs_wb_data = 0;

  always @(negedge CLK) begin
    if (!RESET && run) begin
      chk("rw_excl", mem_read & mem_write, 1'b0);
      if (mem_read) begin
        obs_fetch = mem_address;
        chk("fetch_addr", mem_address, exp_fetch);
      end
      if (mem_write) begin
        obs_wb_addr = mem_address;
        obs_wb_data = mem_writedata;
        chk("wb_expected", exp_wb, 1'b1);
        chk("wb_addr", mem_address, exp_wb_addr);
        chk("wb_data", mem_writedata, exp_wb_data);
      end
      if (!read && !write) begin
        chk("idle_busy", busywait, 1'b0);
        chk("idle_rdata", readdata, last_rd);
      end
    end
  end

  task automatic model_reset();
    for (int s = 0; s < NS; s++) begin
      m_valid[s] = 0;
      m_dirty[s] = 0;
      m_blk[s]   = 0;
    end
    for (int i = 0; i < 1024; i++) ref_mem[i] = phys[i];
    last_rd = 0;
    model_hits = 0;
    model_misses = 0;
  endtask

  task automatic access(input bit wr, input bit rd_too,
                        input logic [31:0] a, input logic [31:0] d,
                        input int rl, input int wl,
                        output logic [31:0] got, output int stall);
    int blk;
    int set;
    int vb;
    int exp_stall;
    bit h;
    bit dv;
    bit done;
    blk = int'(a[11:4]);
    set = blk % NS;
    vb  = m_blk[set];
    h   = m_valid[set] && (m_blk[set] == blk);
    dv  = !h && m_valid[set] && m_dirty[set];
    exp_stall = h ? 0 : (3 + rl + (dv ? wl + 1 : 0));
    rd_lat = rl;
    wb_lat = wl;
    exp_fetch   = 28'(blk);
    exp_wb_addr = 28'(vb);
    exp_wb_data = {ref_mem[vb*4+3], ref_mem[vb*4+2],
                   ref_mem[vb*4+1], ref_mem[vb*4]};
    exp_wb = dv;
    read = wr ? rd_too : 1'b1;
    write = wr;
    address = a;
    writedata = d;
    stall = 0;
    done = 0;
    for (int c = 0; c < 64 && !done; c++) begin
      @(negedge CLK);
      if (busywait) stall++;
      else done = 1;
    end
    if (!done) chk("timeout", 1'b0, 1'b1);
    got = readdata;
    if (!wr) begin
      chk("rdata", readdata, ref_mem[a[11:2]]);
      last_rd = ref_mem[a[11:2]];
    end
    chk("stall", stall, exp_stall);
    if (h) begin
      model_hits++;
    end else begin
      model_misses++;
      m_valid[set] = 1;
      m_blk[set]   = blk;
      m_dirty[set] = 0;
    end
    if (wr) begin
      ref_mem[a[11:2]] = d;
      m_dirty[set] = 1;
    end
    @(posedge CLK);
    #1;
    read = 0;
    write = 0;
    exp_wb = 0;
  endtask

  logic [31:0] got;
  int stall;

  initial begin
    RESET = 1;
    read = 1;
    write = 0;
    address = 32'h40;
    writedata = 0;
    for (int i = 0; i < 1024; i++)
      phys[i] = (i * 32'h9E3779B1) ^ 32'h5A5A0000;
    phys[16] = 32'h22221111;
    phys[17] = 32'h44443333;
    phys[18] = 32'hBBBBAAAA;
    phys[19] = 32'hDDDDCCCC;
    model_reset();
    #3;
    chk("rst_busy", busywait, 1'b0);
    chk("rst_mrd", mem_read, 1'b0);
    chk("rst_mwr", mem_write, 1'b0);
    chk("rst_rdata", readdata, 32'h0);
    @(negedge CLK);
    RESET = 0;
    read = 0;
    #1 run = 1;
    @(posedge CLK);
    #1;

    access(0, 0, 32'h44, 0, 5, 0, got, stall);
    chk("d1_rdata", got, 32'h44443333);
    chk("d1_stall", stall, 8);
    chk("d1_fetch", obs_fetch, 28'h4);
    access(1, 0, 32'h44, 32'hCAFEF00D, 0, 0, got, stall);
    chk("d2_stall", stall, 0);
    access(0, 0, 32'h44, 0, 0, 0, got, stall);
    chk("d3_rdata", got, 32'hCAFEF00D);
    chk("d3_stall", stall, 0);
    access(0, 0, 32'hC4, 0, 1, 3, got, stall);
    chk("d4_stall", stall, 8);
    chk("d4_wb_addr", obs_wb_addr, 28'h4);
    chk("d4_wb_w1", obs_wb_data[63:32], 32'hCAFEF00D);
    chk("d4_fetch", obs_fetch, 28'hC);
`ifdef DCACHE_STATS_EN
    chk("d4_hits", hit_count, 32'd2);
    chk("d4_misses", miss_count, 32'd2);
`endif

    // Reset in the middle of a refill
    rd_lat = 10;
    exp_fetch = 28'h10;
    read = 1;
    address = 32'h104;
    begin
      bit seen;
      seen = 0;
      for (int c = 0; c < 20 && !seen; c++) begin
        @(negedge CLK);
        seen = mem_read;
      end
      chk("d5_fetch_seen", seen, 1'b1);
    end
    #2 RESET = 1;
    #1;
    chk("d5_mrd", mem_read, 1'b0);
    chk("d5_busy", busywait, 1'b0);
    chk("d5_rdata", readdata, 32'h0);
    read = 0;
    model_reset();
    @(negedge CLK);
    RESET = 0;
    @(posedge CLK);
    #1;
    access(0, 0, 32'h44, 0, 0, 0, got, stall);
    chk("d6_stall", stall, 3);
    chk("d6_rdata", got, 32'hCAFEF00D);

    for (int n = 0; n < 400; n++) begin
      logic [31:0] a;
      bit wr;
      a  = ($urandom_range(0, 3) << 7) | ($urandom & 32'h7C);
      wr = ($urandom_range(0, 2) == 0);
      access(wr, 1'($urandom), a, $urandom,
             $urandom_range(0, 4), $urandom_range(0, 4), got, stall);
      repeat ($urandom_range(0, 2)) @(posedge CLK);
      #1;
    end
`ifdef DCACHE_STATS_EN
    chk("hit_count", hit_count, 32'(model_hits));
    chk("miss_count", miss_count, 32'(model_misses));
`endif

    run = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
